// File: rtl/dispatch_scheduler_pkg.sv
// Shared types for the message dispatch scheduler: destination codes,
// FSM state encoding and the queued-message layout.
package dispatch_scheduler_pkg;

  localparam logic [1:0] DEST_LIB    = 2'd0;
  localparam logic [1:0] DEST_FIRE   = 2'd1;
  localparam logic [1:0] DEST_SCHOOL = 2'd2;
  localparam logic [1:0] DEST_RIB    = 2'd3;

  localparam int unsigned MSG_DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [MSG_DATA_W-1:0] data;
    logic [1:0]            dest;
  } fifo_entry_t;

endpackage

// File: rtl/dispatch_scheduler_msg_fifo.sv
// Synchronous FIFO with head peek; pop only retires the head entry.
module msg_fifo #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage, wrapping pointers and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dispatch_scheduler.sv
// Queues destination-tagged messages and drives a 1-to-4 demux one message
// at a time, holding each until acked, retrying on timeout, dropping after
// the final attempt.
module dispatch_scheduler
  import dispatch_scheduler_pkg::*;
#(
  parameter int unsigned DATA_W      = MSG_DATA_W,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ACK_TIMEOUT = 8,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  input  logic [DATA_W-1:0]             req_data,
  input  logic [1:0]                    req_dest,
  output logic                          req_ready,
  input  logic [3:0]                    dest_ack,
  output logic [DATA_W-1:0]             demux_in,
  output logic [1:0]                    demux_sel,
  output logic                          demux_enable,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    sent_count,
  output logic                          drop_pulse,
  output logic [1:0]                    drop_dest
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT);
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);

  state_t              state, state_n;
  logic [TW-1:0]       timer, timer_n;
  logic [RW-1:0]       retry, retry_n;
  logic                retry_pend, pend_n;
  logic [DATA_W-1:0]   in_n;
  logic [1:0]          sel_n;
  logic                en_n;
  logic [7:0]          sent_n;
  logic                drop_n;
  logic [1:0]          drop_dest_n;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [DATA_W+1:0]   head;
  logic [DATA_W-1:0]   head_data;
  logic [1:0]          head_dest;

  assign req_ready = rst_n && !fifo_full;
  assign head_data = head[DATA_W+1:2];
  assign head_dest = head[1:0];

  msg_fifo #(
    .WIDTH (DATA_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_valid && req_ready),
    .pop   (pop),
    .wdata ({req_data, req_dest}),
    .head  (head),
    .count (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // FSM, attempt timer, retry counter and registered demux/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      timer        <= '0;
      retry        <= '0;
      retry_pend   <= 1'b0;
      demux_in     <= '0;
      demux_sel    <= '0;
      demux_enable <= 1'b0;
      sent_count   <= '0;
      drop_pulse   <= 1'b0;
      drop_dest    <= '0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      retry        <= retry_n;
      retry_pend   <= pend_n;
      demux_in     <= in_n;
      demux_sel    <= sel_n;
      demux_enable <= en_n;
      sent_count   <= sent_n;
      drop_pulse   <= drop_n;
      drop_dest    <= drop_dest_n;
    end
  end

  // Next-state logic; the head stays queued across retries and is popped
  // only when the message completes (ack or drop)
  always_comb begin
    state_n     = state;
    timer_n     = timer;
    retry_n     = retry;
    pend_n      = retry_pend;
    in_n        = demux_in;
    sel_n       = demux_sel;
    en_n        = demux_enable;
    sent_n      = sent_count;
    drop_n      = 1'b0;
    drop_dest_n = drop_dest;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        en_n = 1'b0;
        if (!fifo_empty) begin
          in_n    = head_data;
          sel_n   = head_dest;
          en_n    = 1'b1;
          timer_n = '0;
          retry_n = '0;
          pend_n  = 1'b0;
          state_n = SEND;
        end
      end
      SEND: begin
        if (dest_ack[demux_sel]) begin
          pop     = 1'b1;
          sent_n  = sent_count + 8'd1;
          en_n    = 1'b0;
          pend_n  = 1'b0;
          state_n = GAP;
        end else if (timer == TIMER_LAST && retry == RETRY_LAST) begin
          pop         = 1'b1;
          drop_n      = 1'b1;
          drop_dest_n = demux_sel;
          en_n        = 1'b0;
          pend_n      = 1'b0;
          state_n     = GAP;
        end else if (timer == TIMER_LAST) begin
          retry_n = retry + 1'b1;
          pend_n  = 1'b1;
          en_n    = 1'b0;
          state_n = GAP;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      GAP: begin
        if (retry_pend) begin
          en_n    = 1'b1;
          timer_n = '0;
          pend_n  = 1'b0;
          state_n = SEND;
        end else if (!fifo_empty) begin
          in_n    = head_data;
          sel_n   = head_dest;
          en_n    = 1'b1;
          timer_n = '0;
          retry_n = '0;
          state_n = SEND;
        end else begin
          en_n    = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        en_n    = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Directed bench for dispatch_scheduler with hand-computed expectations.
module tb_dispatch_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic [3:0] req_data;
  logic [1:0] req_dest;
  logic       req_ready;
  logic [3:0] dest_ack;
  logic [3:0] demux_in;
  logic [1:0] demux_sel;
  logic       demux_enable;
  logic [2:0] fifo_level;
  logic [7:0] sent_count;
  logic       drop_pulse;
  logic [1:0] drop_dest;

  int n_cmp = 0;
  int n_err = 0;
  int n;
  logic saw_drop;

  always #5 clk = ~clk;

  dispatch_scheduler #(
    .DATA_W      (4),
    .FIFO_DEPTH  (4),
    .ACK_TIMEOUT (8),
    .MAX_RETRY   (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_dest     (req_dest),
    .req_ready    (req_ready),
    .dest_ack     (dest_ack),
    .demux_in     (demux_in),
    .demux_sel    (demux_sel),
    .demux_enable (demux_enable),
    .fifo_level   (fifo_level),
    .sent_count   (sent_count),
    .drop_pulse   (drop_pulse),
    .drop_dest    (drop_dest)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts consecutive samples with enable high, bounded to 20
  task automatic measure_high(output int cnt, output logic drop_seen);
    cnt = 0;
    drop_seen = 1'b0;
    while (demux_enable === 1'b1 && cnt < 20) begin
      if (drop_pulse === 1'b1) drop_seen = 1'b1;
      cnt++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_data = '0; req_dest = '0; dest_ack = '0;
    #1;
    chk("rst_enable", demux_enable, 0);
    chk("rst_in", demux_in, 0);
    chk("rst_sel", demux_sel, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_sent", sent_count, 0);
    chk("rst_drop", drop_pulse, 0);
    chk("rst_ready", req_ready, 0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", req_ready, 1);
    tick();
    chk("idle_enable", demux_enable, 0);

    // T1: single message 0xA to school, acked after 3 enable cycles
    req_valid = 1'b1; req_data = 4'hA; req_dest = 2'd2;
    tick();
    req_valid = 1'b0;
    chk("t1_level_push", fifo_level, 1);
    chk("t1_en_pre", demux_enable, 0);
    tick();
    chk("t1_en", demux_enable, 1);
    chk("t1_sel", demux_sel, 2);
    chk("t1_in", demux_in, 4'hA);
    tick();
    chk("t1_en2", demux_enable, 1);
    tick();
    chk("t1_en3", demux_enable, 1);
    dest_ack = 4'b0100;
    tick();
    dest_ack = 4'b0000;
    chk("t1_en_off", demux_enable, 0);
    chk("t1_sent", sent_count, 1);
    chk("t1_level", fifo_level, 0);
    chk("t1_drop", drop_pulse, 0);
    tick();
    chk("t1_gap", demux_enable, 0);
    tick();

    // T2: four back-to-back pushes fill the FIFO, then all acked
    req_valid = 1'b1; req_data = 4'h1; req_dest = 2'd0;
    tick();
    chk("t2_level1", fifo_level, 1);
    req_data = 4'h2; req_dest = 2'd1;
    tick();
    chk("t2_en_m1", demux_enable, 1);
    chk("t2_sel_m1", demux_sel, 0);
    req_data = 4'h3; req_dest = 2'd2;
    tick();
    req_data = 4'h4; req_dest = 2'd3;
    tick();
    req_valid = 1'b0;
    chk("t2_full_level", fifo_level, 4);
    chk("t2_full_ready", req_ready, 0);
    dest_ack = 4'b1111;
    tick();
    chk("t2_m1_done_en", demux_enable, 0);
    chk("t2_m1_sent", sent_count, 2);
    chk("t2_m1_ready", req_ready, 1);
    tick();
    chk("t2_m2_en", demux_enable, 1);
    chk("t2_m2_sel", demux_sel, 1);
    chk("t2_m2_in", demux_in, 4'h2);
    tick();
    chk("t2_m2_off", demux_enable, 0);
    tick();
    chk("t2_m3_en", demux_enable, 1);
    chk("t2_m3_sel", demux_sel, 2);
    chk("t2_m3_in", demux_in, 4'h3);
    tick();
    chk("t2_m3_off", demux_enable, 0);
    tick();
    chk("t2_m4_en", demux_enable, 1);
    chk("t2_m4_sel", demux_sel, 3);
    chk("t2_m4_in", demux_in, 4'h4);
    tick();
    chk("t2_m4_off", demux_enable, 0);
    chk("t2_sent", sent_count, 5);
    chk("t2_level", fifo_level, 0);
    tick();
    dest_ack = 4'b0000;
    chk("t2_idle", demux_enable, 0);

    // T3: dest 1 never acks -> 3 attempts of 8 cycles, then drop; next msg starts
    req_valid = 1'b1; req_data = 4'h5; req_dest = 2'd1;
    tick();
    req_data = 4'h6; req_dest = 2'd0;
    tick();
    req_valid = 1'b0;
    chk("t3_en", demux_enable, 1);
    chk("t3_sel", demux_sel, 1);
    chk("t3_level", fifo_level, 2);
    for (int a = 0; a < 3; a++) begin
      measure_high(n, saw_drop);
      chk($sformatf("t3_len_a%0d", a), n, 8);
      chk($sformatf("t3_nodrop_hi_a%0d", a), saw_drop, 0);
      if (a < 2) begin
        chk($sformatf("t3_nodrop_gap_a%0d", a), drop_pulse, 0);
        tick();
        chk($sformatf("t3_reen_a%0d", a), demux_enable, 1);
        chk($sformatf("t3_resel_a%0d", a), demux_sel, 1);
      end
    end
    chk("t3_drop", drop_pulse, 1);
    chk("t3_drop_dest", drop_dest, 1);
    chk("t3_sent", sent_count, 5);
    chk("t3_level_after", fifo_level, 1);
    tick();
    chk("t3_drop_1cyc", drop_pulse, 0);
    chk("t3_next_en", demux_enable, 1);
    chk("t3_next_sel", demux_sel, 0);
    chk("t3_next_in", demux_in, 4'h6);
    dest_ack = 4'b0001;
    tick();
    dest_ack = 4'b0000;
    chk("t3_next_sent", sent_count, 6);
    chk("t3_next_level", fifo_level, 0);
    tick();
    tick();

    // T4: dest 3, wrong-bit ack in attempt 1, real ack on 2nd cycle of attempt 2
    req_valid = 1'b1; req_data = 4'h9; req_dest = 2'd3;
    tick();
    req_valid = 1'b0;
    tick();
    chk("t4_en", demux_enable, 1);
    chk("t4_sel", demux_sel, 3);
    dest_ack = 4'b0001;
    tick();
    dest_ack = 4'b0000;
    chk("t4_wrong_ack_ignored", demux_enable, 1);
    chk("t4_wrong_ack_sent", sent_count, 6);
    measure_high(n, saw_drop);
    chk("t4_a1_rest_len", n, 7);
    chk("t4_a1_drop", drop_pulse, 0);
    tick();
    chk("t4_a2_en", demux_enable, 1);
    tick();
    dest_ack = 4'b1000;
    tick();
    dest_ack = 4'b0000;
    chk("t4_done_en", demux_enable, 0);
    chk("t4_sent", sent_count, 7);
    chk("t4_drop", drop_pulse, 0);
    chk("t4_level", fifo_level, 0);
    tick();
    tick();
    chk("t4_idle_drop", drop_pulse, 0);

    // T5: ack on the final timeout cycle of attempt 3 counts as sent
    req_valid = 1'b1; req_data = 4'hC; req_dest = 2'd2;
    tick();
    req_valid = 1'b0;
    tick();
    measure_high(n, saw_drop);
    chk("t5_a1_len", n, 8);
    tick();
    measure_high(n, saw_drop);
    chk("t5_a2_len", n, 8);
    tick();
    chk("t5_a3_en", demux_enable, 1);
    for (int i = 0; i < 7; i++) tick();
    chk("t5_a3_last_en", demux_enable, 1);
    dest_ack = 4'b0100;
    tick();
    dest_ack = 4'b0000;
    chk("t5_en_off", demux_enable, 0);
    chk("t5_sent", sent_count, 8);
    chk("t5_no_drop", drop_pulse, 0);
    chk("t5_level", fifo_level, 0);
    tick();
    chk("t5_no_drop_late", drop_pulse, 0);
    tick();

    // T6: reset mid-SEND with two entries queued
    req_valid = 1'b1; req_data = 4'h3; req_dest = 2'd1;
    tick();
    req_data = 4'h7; req_dest = 2'd0;
    tick();
    req_valid = 1'b0;
    chk("t6_en", demux_enable, 1);
    chk("t6_level", fifo_level, 2);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_en", demux_enable, 0);
    chk("t6_rst_level", fifo_level, 0);
    chk("t6_rst_ready", req_ready, 0);
    chk("t6_rst_sent", sent_count, 0);
    chk("t6_rst_drop", drop_pulse, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t6_post_en_%0d", i), demux_enable, 0);
      chk($sformatf("t6_post_drop_%0d", i), drop_pulse, 0);
      chk($sformatf("t6_post_level_%0d", i), fifo_level, 0);
    end
    chk("t6_post_ready", req_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
